// File: rtl/matmul_pkg.sv
// Shared types and sizing for the sigma*J energy scheduler.
// Default sizing plus the width derivation shared with the MAC array.
package matmul_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  localparam int DEF_VECTOR_SIZE     = 256;
  localparam int DEF_J_ELEMENT_WIDTH = 4;
  localparam int DEF_J_COLS_PER_READ = 4;
  localparam int DEF_MAX_OUTSTANDING = 2;

  localparam int NUM_J_CHUNKS = DEF_VECTOR_SIZE / DEF_J_COLS_PER_READ;
  localparam int CHUNK_CNT_W  = $clog2(NUM_J_CHUNKS + 1);
  localparam int OUT_CNT_W    = $clog2(DEF_MAX_OUTSTANDING + 1);

  // Signed width able to hold any sigma*J sum without overflow.
  function automatic int energy_width(input int vs, input int jw);
    return 2 * $clog2(vs) + jw + 1;
  endfunction

endpackage

// File: rtl/matmul_outstanding_ctr.sv
// Up/down credit counter for granted-but-unanswered memory reads.
// Decrements on an empty counter are ignored.
module matmul_outstanding_ctr #(
  parameter int MAX = 2,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         dec_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == W'(MAX));
  assign dec_ok  = dec_i && !empty_o;

  // Next count: simultaneous inc and dec cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_ok) cnt_d = cnt_q + 1'b1;
    else if (!inc_i && dec_ok) cnt_d = cnt_q - 1'b1;
  end

  // Credit count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/matmul_chunk_scheduler.sv
// Job controller: issues one J read per chunk, accumulates array sums,
// aborts early once the energy bound is reached, then reports.
module matmul_chunk_scheduler #(
  parameter int VECTOR_SIZE     = 256,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int J_COLS_PER_READ = 4,
  parameter int ADDR_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ENERGY_WIDTH    =
    matmul_pkg::energy_width(VECTOR_SIZE, J_ELEMENT_WIDTH),
  localparam int CW = $clog2(VECTOR_SIZE / J_COLS_PER_READ + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [VECTOR_SIZE-1:0]         job_sigma,
  input  logic signed [ENERGY_WIDTH-1:0] job_bound,
  input  logic [ADDR_WIDTH-1:0]          job_base_addr,
  output logic                           mem_req,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic                           mem_gnt,
  input  logic                           mem_rvalid,
  output logic [VECTOR_SIZE-1:0]         dp_sigma,
  input  logic signed [ENERGY_WIDTH-1:0] dp_chunk_sum,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic signed [ENERGY_WIDTH-1:0] res_energy,
  output logic                           res_exceeded,
  output logic [CW-1:0]                  res_chunks
);

  import matmul_pkg::*;

  localparam int          NCH   = VECTOR_SIZE / J_COLS_PER_READ;
  localparam logic [CW-1:0] NCH_C = CW'(NCH);

  sched_state_e                   state_q, state_d;
  logic [VECTOR_SIZE-1:0]         sigma_q, sigma_d;
  logic signed [ENERGY_WIDTH-1:0] bound_q, bound_d;
  logic signed [ENERGY_WIDTH-1:0] acc_q, acc_d, acc_sum;
  logic [ADDR_WIDTH-1:0]          base_q, base_d;
  logic [CW-1:0]                  issue_q, issue_d;
  logic [CW-1:0]                  recv_q, recv_d;
  logic                           pend_q, pend_d;
  logic                           inc, rv_ok;
  logic                           out_full, out_empty;

  matmul_outstanding_ctr #(
    .MAX (MAX_OUTSTANDING)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (inc),
    .dec_i   (rv_ok),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  assign mem_addr   = base_q + ADDR_WIDTH'(issue_q);
  assign dp_sigma   = sigma_q;
  assign res_energy = acc_q;
  assign res_chunks = recv_q;
  assign acc_sum    = acc_q + dp_chunk_sum;

  // Request gating, counters and state transitions.
  always_comb begin
    state_d      = state_q;
    sigma_d      = sigma_q;
    bound_d      = bound_q;
    base_d       = base_q;
    acc_d        = acc_q;
    issue_d      = issue_q;
    recv_d       = recv_q;
    job_ready    = 1'b0;
    res_valid    = 1'b0;
    res_exceeded = 1'b0;
    rv_ok        = mem_rvalid && !out_empty;
    mem_req      = ((state_q == S_ISSUE) && (issue_q < NCH_C) && !out_full)
                || ((state_q == S_DRAIN) && pend_q);
    inc          = mem_req && mem_gnt;
    pend_d       = mem_req && !mem_gnt;
    unique case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          sigma_d = job_sigma;
          bound_d = job_bound;
          base_d  = job_base_addr;
          acc_d   = '0;
          issue_d = '0;
          recv_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (inc) issue_d = issue_q + 1'b1;
        if (rv_ok) begin
          acc_d  = acc_sum;
          recv_d = recv_q + 1'b1;
          if (recv_q + 1'b1 == NCH_C) state_d = S_DONE;
          else if (acc_sum >= bound_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_empty && !pend_q) state_d = S_DONE;
      end
      S_DONE: begin
        res_valid    = 1'b1;
        res_exceeded = (acc_q >= bound_q);
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job context and progress registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sigma_q <= '0;
      bound_q <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      issue_q <= '0;
      recv_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sigma_q <= sigma_d;
      bound_q <= bound_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      pend_q  <= pend_d;
    end
  end

  a_rvalid_proto: assert property (
    @(posedge clk) disable iff (!rst_n) !(mem_rvalid && out_empty)
  ) else $error("mem_rvalid with no read outstanding");

endmodule
